hack_divider_mmio: RTL and testbench

Memory-mapped iterative signed divider that sits on the Hack CPU data bus beside data RAM. It consumes the CPU's `addrM`/`outM`/`writeM` outputs and returns read data for the `inM` mux. Assembly programs offload `ram[2] = ram[0] / ram[1]` and `ram[3] = ram[0] % ram[1]` to hardware: write the operands, start the unit, then poll STATUS. Results follow Euclidean convention, so the remainder is always non-negative.

---
 rtl/hack_divider_mmio.sv | 152 +++++++++++++++
 tb/tb_hack_divider_mmio.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hack_divider_mmio.sv
// Memory-mapped iterative signed divider for the Hack data bus.
// Euclidean quotient/remainder via 16-step restoring division with sign fix-up.
module hack_divider_mmio #(
  parameter logic [14:0] BASE_ADDR = 15'h6010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addrM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic        sel,
  output logic [15:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIX} state_t;

  state_t      state_reg, state_next;
  logic [15:0] dividend_reg, divisor_reg, quotient_reg, remainder_reg;
  logic        done_reg, dz_reg, ovf_reg;
  logic        sign_a_reg, sign_b_reg;
  logic [15:0] b_abs_reg;
  logic [15:0] work_reg;   // dividend bits shift out the top, quotient bits in the bottom
  logic [15:0] prem_reg;
  logic [3:0]  cnt_reg;

  logic [14:0] offset;
  logic [4:0]  wr_hit;
  logic        start_req;

  // Addresses below the base wrap to a large offset, so one compare covers both bounds.
  assign offset = addrM - BASE_ADDR;
  assign sel    = (offset < 15'd5);
  assign busy   = (state_reg != S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_wr
      assign wr_hit[gi] = writeM && (offset == 15'(gi));
    end
  endgenerate

  assign start_req = wr_hit[4] && outM[0];

  always_comb begin
    rdata = 16'd0;
    case (offset)
      15'd0: rdata = dividend_reg;
      15'd1: rdata = divisor_reg;
      15'd2: rdata = quotient_reg;
      15'd3: rdata = remainder_reg;
      15'd4: rdata = {12'd0, ovf_reg, dz_reg, done_reg, busy};
      default: rdata = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_req) state_next = S_LOAD;
      S_LOAD: state_next = S_ITER;
      S_ITER: if (cnt_reg == 4'd0) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Restoring step on a 17-bit trial remainder.
  logic [16:0] trial, diff;
  logic        ge;
  assign trial = {prem_reg, work_reg[15]};
  assign diff  = trial - {1'b0, b_abs_reg};
  assign ge    = (trial >= {1'b0, b_abs_reg});

  // Sign correction applied on the FIX edge; q0 = work_reg, r0 = prem_reg.
  logic [15:0] q_fix, r_fix, q0_inc;
  logic        ovf_fix;
  always_comb begin
    q_fix   = work_reg;
    r_fix   = prem_reg;
    ovf_fix = 1'b0;
    q0_inc  = work_reg + 16'd1;
    if (dz_reg) begin
      q_fix = 16'd0;
      r_fix = 16'h7FFF;
    end else if (sign_a_reg && (prem_reg != 16'd0)) begin
      q_fix = sign_b_reg ? q0_inc : (16'd0 - q0_inc);
      r_fix = b_abs_reg - prem_reg;
    end else begin
      q_fix   = (sign_a_reg ^ sign_b_reg) ? (16'd0 - work_reg) : work_reg;
      // Only -32768 / -1 yields a positive quotient with bit 15 set.
      ovf_fix = !(sign_a_reg ^ sign_b_reg) && work_reg[15];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_reg  <= 16'd0;
      divisor_reg   <= 16'd0;
      quotient_reg  <= 16'd0;
      remainder_reg <= 16'd0;
      done_reg      <= 1'b0;
      dz_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      b_abs_reg     <= 16'd0;
      work_reg      <= 16'd0;
      prem_reg      <= 16'd0;
      cnt_reg       <= 4'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (wr_hit[0]) dividend_reg <= outM;
          if (wr_hit[1]) divisor_reg  <= outM;
          if (start_req) begin
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
          end
        end
        S_LOAD: begin
          sign_a_reg <= dividend_reg[15];
          sign_b_reg <= divisor_reg[15];
          work_reg   <= dividend_reg[15] ? (16'd0 - dividend_reg) : dividend_reg;
          b_abs_reg  <= divisor_reg[15] ? (16'd0 - divisor_reg) : divisor_reg;
          dz_reg     <= (divisor_reg == 16'd0);
          prem_reg   <= 16'd0;
          cnt_reg    <= 4'd15;
        end
        S_ITER: begin
          prem_reg <= ge ? diff[15:0] : trial[15:0];
          work_reg <= {work_reg[14:0], ge};
          cnt_reg  <= cnt_reg - 4'd1;
        end
        S_FIX: begin
          quotient_reg  <= q_fix;
          remainder_reg <= r_fix;
          ovf_reg       <= ovf_fix;
          done_reg      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_divider_mmio.sv
// Directed bench for hack_divider_mmio: vector table of divisions plus
// protocol, decode and mid-operation reset sequences.
module tb_hack_divider_mmio;

  localparam logic [14:0] BASE = 15'h6010;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addrM;
  logic [15:0] outM;
  logic        writeM;
  logic        sel;
  logic [15:0] rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  hack_divider_mmio #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addrM(addrM), .outM(outM),
    .writeM(writeM), .sel(sel), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic [15:0] st;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    addrM = a; outM = d; writeM = 1'b1;
    @(posedge clk); #1;
    writeM = 1'b0; addrM = 15'd0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [15:0] d);
    addrM = a; writeM = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] d;
  int cyc;

  initial begin
    vecs[0]  = '{16'd42,     16'd7,      16'd6,      16'd0,      16'h0002};
    vecs[1]  = '{16'd26,     16'd7,      16'd3,      16'd5,      16'h0002};
    vecs[2]  = '{16'd3,      16'd4,      16'd0,      16'd3,      16'h0002};
    vecs[3]  = '{16'hFFD6,   16'd7,      16'hFFFA,   16'd0,      16'h0002};
    vecs[4]  = '{16'hFFF9,   16'd2,      16'hFFFC,   16'd1,      16'h0002};
    vecs[5]  = '{16'd7,      16'hFFFE,   16'hFFFD,   16'd1,      16'h0002};
    vecs[6]  = '{16'hFFF9,   16'hFFFE,   16'd4,      16'd1,      16'h0002};
    vecs[7]  = '{16'd0,      16'hFFFD,   16'd0,      16'd0,      16'h0002};
    vecs[8]  = '{16'd0,      16'd0,      16'd0,      16'h7FFF,   16'h0006};
    vecs[9]  = '{16'd1,      16'd0,      16'd0,      16'h7FFF,   16'h0006};
    vecs[10] = '{16'h8000,   16'hFFFF,   16'h8000,   16'd0,      16'h000A};

    reset = 1'b1; addrM = 15'd0; outM = 16'd0; writeM = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      rd(BASE + 15'(i), d);
      chk($sformatf("reset_reg%0d", i), d, 16'd0);
    end
    chk("reset_busy", busy, 1'b0);

    for (int i = 0; i < 11; i++) begin
      wr(BASE + 15'd0, vecs[i].a);
      wr(BASE + 15'd1, vecs[i].b);
      wr(BASE + 15'd4, 16'h0001);
      wait_idle(cyc);
      $display("vec %0d: a=0x%04h b=0x%04h busy_cycles=%0d", i, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("v%0d_busy_cycles", i), cyc, 18);
      rd(BASE + 15'd2, d); chk($sformatf("v%0d_quot", i), d, vecs[i].q);
      rd(BASE + 15'd3, d); chk($sformatf("v%0d_rem", i), d, vecs[i].r);
      rd(BASE + 15'd4, d); chk($sformatf("v%0d_status", i), d, vecs[i].st);
    end

    // Operand write and restart while busy are both ignored; 100/7 = 14 r 2.
    wr(BASE + 15'd0, 16'd100);
    wr(BASE + 15'd1, 16'd7);
    wr(BASE + 15'd4, 16'h0001);
    rd(BASE + 15'd4, d); chk("prot_status_busy", d, 16'h0001);
    repeat (3) @(posedge clk);
    #1;
    wr(BASE + 15'd0, 16'd99);
    wr(BASE + 15'd4, 16'h0001);
    rd(BASE + 15'd2, d); chk("prot_old_quot", d, 16'h8000);
    rd(BASE + 15'd0, d); chk("prot_dividend_kept", d, 16'd100);
    wait_idle(cyc);
    $display("protocol: busy_cycles_after_writes=%0d", cyc);
    chk("prot_idle", busy, 1'b0);
    rd(BASE + 15'd2, d); chk("prot_quot", d, 16'd14);
    rd(BASE + 15'd3, d); chk("prot_rem", d, 16'd2);
    rd(BASE + 15'd0, d); chk("prot_dividend_after", d, 16'd100);

    // Out-of-range writes are invisible; writes to QUOTIENT are dropped.
    addrM = BASE - 15'd1; outM = 16'h5555; writeM = 1'b1;
    #1;
    chk("dec_lo_sel", sel, 1'b0);
    chk("dec_lo_rdata", rdata, 16'd0);
    @(posedge clk); #1;
    addrM = BASE + 15'd5; outM = 16'h5555; writeM = 1'b1;
    #1;
    chk("dec_hi_sel", sel, 1'b0);
    chk("dec_hi_rdata", rdata, 16'd0);
    @(posedge clk); #1;
    writeM = 1'b0;
    rd(BASE + 15'd4, d); chk("dec_top_sel", sel, 1'b1);
    rd(BASE + 15'd0, d); chk("dec_dividend", d, 16'd100);
    rd(BASE + 15'd1, d); chk("dec_divisor", d, 16'd7);
    wr(BASE + 15'd2, 16'h1234);
    rd(BASE + 15'd2, d); chk("dec_quot_ro", d, 16'd14);
    rd(BASE + 15'd4, d); chk("dec_status", d, 16'h0002);
    $display("decode checks done");

    // Reset during ITER clears everything.
    wr(BASE + 15'd0, 16'd5);
    wr(BASE + 15'd1, 16'd3);
    wr(BASE + 15'd4, 16'h0001);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 15'(i), d);
      chk($sformatf("rst_reg%0d", i), d, 16'd0);
    end
    $display("mid-operation reset checks done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
